// File: rtl/uart_report_scheduler.sv
// uart_report_scheduler: periodic XADC sample -> uart_temp_tx report sequencer
// Ports: clk/rst (sync active-high), enable runs the report timer; sample_req/sample_valid/
// sample_temp_x100 talk to the XADC reader; tx_start/tx_temp_x100/tx_busy talk to uart_temp_tx;
// report_cnt (wrapping), timeout_cnt (saturating) and alarm are status.
// Define REPORT_ALARM_EN for the hysteresis alarm that shortens the period by FAST_DIV.
module uart_report_scheduler #(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int PERIOD_MS      = 1000,
  parameter int SAMPLE_TIMEOUT = 1024,
  parameter int ALARM_HI_X100  = 8000,
  parameter int ALARM_LO_X100  = 7500,
  parameter int FAST_DIV       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        sample_req,
  input  logic        sample_valid,
  input  logic [31:0] sample_temp_x100,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [31:0] tx_temp_x100,
  output logic [15:0] report_cnt,
  output logic [7:0]  timeout_cnt,
  output logic        alarm
);
  localparam int PERIOD_CYC = CLK_FREQ / 1000 * PERIOD_MS;
  localparam int CW = $clog2(PERIOD_CYC + 1);
  localparam int TW = $clog2(SAMPLE_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT_S, ISSUE, WAIT_HI, WAIT_LO} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] term;
  logic [TW-1:0] timer;
  logic pending;
  logic tick;
  // a hysteresis band and a positive divisor are required for the alarm build to make sense
  if (ALARM_LO_X100 > ALARM_HI_X100 || FAST_DIV < 1) begin : g_bad_cfg
    $error("uart_report_scheduler: ALARM_LO_X100 must not exceed ALARM_HI_X100 and FAST_DIV must be >= 1");
  end
`ifdef REPORT_ALARM_EN
  assign term = alarm ? CW'(PERIOD_CYC / FAST_DIV - 1) : CW'(PERIOD_CYC - 1);
  always_ff @(posedge clk)
    if (rst) alarm <= 1'b0;
    else if (state == WAIT_S && sample_valid)
      alarm <= $signed(sample_temp_x100) >= ALARM_HI_X100 ? 1'b1 :
               $signed(sample_temp_x100) < ALARM_LO_X100 ? 1'b0 : alarm;
`else
  assign term = CW'(PERIOD_CYC - 1);
  assign alarm = 1'b0;
`endif
  // >= rather than == so a counter stranded above a freshly shortened period wraps at once
  assign tick = enable && cnt >= term;
  // start pulses are decoded from state; tx_start also gates on live busy so it can never overlap it
  assign sample_req = state == REQ;
  assign tx_start = state == ISSUE && !tx_busy;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pending <= 1'b0;
      timer <= '0;
      tx_temp_x100 <= '0;
      report_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      cnt <= tick || !enable ? '0 : cnt + CW'(1);
      pending <= enable && (tick || (pending && state != REQ));
      timer <= timer + TW'(1);
      case (state)
        IDLE: if (pending) state <= REQ;
        REQ: begin
          timer <= '0;
          state <= WAIT_S;
        end
        WAIT_S:
          if (sample_valid) begin
            tx_temp_x100 <= sample_temp_x100;
            state <= ISSUE;
          end else if (timer == TW'(SAMPLE_TIMEOUT - 1)) begin
            timeout_cnt <= timeout_cnt + 8'(timeout_cnt != 8'hFF);
            state <= IDLE;
          end
        ISSUE:
          if (!tx_busy) begin
            timer <= '0;
            state <= WAIT_HI;
          end
        WAIT_HI:
          if (tx_busy) begin
            report_cnt <= report_cnt + 16'd1;
            state <= WAIT_LO;
          end else if (timer == TW'(1)) state <= IDLE;
        WAIT_LO: if (!tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_report_scheduler.sv
// tb_uart_report_scheduler: scoreboard bench for uart_report_scheduler
module tb_uart_report_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic sample_valid = 1'b0;
  logic force_busy = 1'b0;
  logic [31:0] sample_temp_x100 = '0;
  logic tx_busy;
  logic sample_req;
  logic tx_start;
  logic alarm;
  logic [31:0] tx_temp_x100;
  logic [15:0] report_cnt;
  logic [7:0] timeout_cnt;
  int cyc = 0;
  int busy_left = 0;
  int busy_len = 50;
  int total = 0;
  int bad = 0;
  typedef struct {int val; int cyc;} tx_t;
  int exp_req[$];
  tx_t exp_tx[$];
  tx_t mon_t;

  uart_report_scheduler #(
    .CLK_FREQ(10_000), .PERIOD_MS(10), .SAMPLE_TIMEOUT(16),
    .ALARM_HI_X100(8000), .ALARM_LO_X100(7500), .FAST_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .sample_req(sample_req), .sample_valid(sample_valid), .sample_temp_x100(sample_temp_x100),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_temp_x100(tx_temp_x100),
    .report_cnt(report_cnt), .timeout_cnt(timeout_cnt), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // transmitter model: busy for busy_len cycles starting the cycle after tx_start
  assign tx_busy = force_busy || busy_left != 0;
  always @(posedge clk) begin
    cyc <= rst ? 0 : cyc + 1;
    busy_left <= tx_start ? busy_len : busy_left > 0 ? busy_left - 1 : 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_chk();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("rst sample_req", sample_req, 0);
    check("rst tx_start", tx_start, 0);
    check("rst tx_temp_x100", tx_temp_x100, 0);
    check("rst report_cnt", report_cnt, 0);
    check("rst timeout_cnt", timeout_cnt, 0);
    check("rst alarm", alarm, 0);
    rst = 1'b0;
  endtask

  task automatic pulse(input int n, input int v);
    wait_cyc(n);
    sample_valid = 1'b1;
    sample_temp_x100 = v;
    wait_cyc(n + 1);
    sample_valid = 1'b0;
  endtask

  task automatic push_tx(input int v, input int c);
    tx_t t;
    t.val = v;
    t.cyc = c;
    exp_tx.push_back(t);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sample_req) begin
        if (exp_req.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected sample_req at cycle %0d, none expected", cyc);
        end else check("sample_req cycle", cyc, exp_req.pop_front());
      end
      if (tx_start) begin
        check("tx_start while tx_busy", tx_busy, 0);
        check("tx_start with sample_req", sample_req, 0);
        if (exp_tx.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected tx_start at cycle %0d value 0x%0h, none expected", cyc, tx_temp_x100);
        end else begin
          mon_t = exp_tx.pop_front();
          check("tx_start cycle", cyc, mon_t.cyc);
          check("tx_temp_x100 at start", tx_temp_x100, mon_t.val);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    enable = 1'b1;
    reset_chk();
    exp_req.push_back(101);
    exp_req.push_back(201);
    exp_req.push_back(301);
    push_tx(-1234, 105);
    pulse(104, -1234);
    wait_cyc(160);
    check("report_cnt after frame 1", report_cnt, 1);
    check("timeout_cnt after frame 1", timeout_cnt, 0);
    wait_cyc(220);
    check("timeout_cnt after first timeout", timeout_cnt, 1);
    check("report_cnt after first timeout", report_cnt, 1);
    wait_cyc(290);
    force_busy = 1'b1;
    push_tx(1111, 510);
    exp_req.push_back(563);
    exp_req.push_back(601);
    exp_req.push_back(701);
    pulse(303, 1111);
    wait_cyc(450);
    check("tx_temp_x100 held while busy", tx_temp_x100, 1111);
    check("report_cnt while held", report_cnt, 1);
    wait_cyc(510);
    force_busy = 1'b0;
    wait_cyc(570);
    check("report_cnt after held frame", report_cnt, 2);
    wait_cyc(650);
    check("timeout_cnt after pending frames", timeout_cnt, 3);
    push_tx(2222, 704);
    pulse(703, 2222);
    wait_cyc(710);
    check("report_cnt frame 3", report_cnt, 3);
    wait_cyc(720);
    reset_chk();
    exp_req.push_back(101);
    push_tx(3333, 106);
    wait_cyc(103);
    enable = 1'b0;
    pulse(105, 3333);
    wait_cyc(170);
    check("report_cnt after enable drop", report_cnt, 1);
    wait_cyc(400);
    check("outstanding events after enable drop", exp_req.size() + exp_tx.size(), 0);
    enable = 1'b1;
    reset_chk();
    for (int k = 0; k < 300; k++) exp_req.push_back(101 + 100 * k);
    wait_cyc(30050);
    check("timeout_cnt saturated", timeout_cnt, 8'hFF);
    check("report_cnt during timeouts", report_cnt, 0);
    enable = 1'b0;
    wait_cyc(30200);
`ifdef REPORT_ALARM_EN
    busy_len = 2;
    enable = 1'b1;
    reset_chk();
    exp_req.push_back(101);
    exp_req.push_back(126);
    exp_req.push_back(151);
    exp_req.push_back(251);
    push_tx(8000, 103);
    push_tx(7600, 128);
    push_tx(7499, 153);
    pulse(102, 8000);
    wait_cyc(110);
    check("alarm after 8000", alarm, 1);
    pulse(127, 7600);
    wait_cyc(135);
    check("alarm after 7600", alarm, 1);
    pulse(152, 7499);
    wait_cyc(160);
    check("alarm after 7499", alarm, 0);
    wait_cyc(260);
    enable = 1'b0;
    wait_cyc(300);
`endif
    check("outstanding events at end", exp_req.size() + exp_tx.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
